// File: rtl/ccl_frame_ctrl_pkg.sv
// rtl/ccl_frame_ctrl_pkg.sv - shared widths and FSM state encoding for the CCL frame controller
//
// Purpose: the single place that fixes label/coordinate widths and the
// controller state encoding. Every other file imports this package.
// Ports: none.
package ccl_frame_ctrl_pkg;

  localparam int WORD_SIZE = 8;   // label / object id width
  localparam int LOC_SIZE  = 10;  // raster coordinate / centroid width

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SCAN    = 3'd1;
  localparam logic [2:0] ST_DRAIN   = 3'd2;
  localparam logic [2:0] ST_READ    = 3'd3;
  localparam logic [2:0] ST_PRESENT = 3'd4;
  localparam logic [2:0] ST_FINISH  = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    SCAN    = ST_SCAN,
    DRAIN   = ST_DRAIN,
    READ    = ST_READ,
    PRESENT = ST_PRESENT,
    FINISH  = ST_FINISH
  } state_t;

endpackage

// File: rtl/ccl_frame_ctrl_if.sv
// rtl/ccl_frame_ctrl_if.sv - object record valid/ready channel
//
// Purpose: carries one object record (id plus centroid) per handshake.
// Signals: out_valid, out_id, out_x, out_y (master drives); out_ready (slave drives).
// Modports: master = record producer (the controller), slave = record consumer.
interface ccl_frame_ctrl_if;
  import ccl_frame_ctrl_pkg::*;

  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_id;
  logic [LOC_SIZE-1:0]  out_x;
  logic [LOC_SIZE-1:0]  out_y;

  modport master (output out_valid, output out_id, output out_x, output out_y,
                  input out_ready);
  modport slave  (input out_valid, input out_id, input out_x, input out_y,
                  output out_ready);
endinterface

// File: rtl/ccl_frame_ctrl_raster_counter.sv
// rtl/ccl_frame_ctrl_raster_counter.sv - raster x/y generator for one frame
//
// Purpose: steps (x, y) through the frame in raster order, one position per
// advance, and wraps to (0, 0) after the last pixel.
// Ports: clk, reset (async, active-high); clear forces (0, 0);
//        advance steps one pixel; x, y current coordinate;
//        last is high while (x, y) is the final pixel of the frame.
module raster_counter
  import ccl_frame_ctrl_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                advance,
  output logic [LOC_SIZE-1:0] x,
  output logic [LOC_SIZE-1:0] y,
  output logic                last
);

  logic x_end;
  assign x_end = (x == LOC_SIZE'(IMG_W - 1));
  assign last  = x_end && (y == LOC_SIZE'(IMG_H - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_end) begin
        x <= '0;
        // the last pixel returns y to 0 so the coordinate rests at the origin
        y <= last ? '0 : y + LOC_SIZE'(1);
      end else begin
        x <= x + LOC_SIZE'(1);
      end
    end
  end

endmodule

// File: rtl/ccl_frame_ctrl.sv
// rtl/ccl_frame_ctrl.sv - frame sequencing and object readout for connected-component labeling
//
// Purpose: scans one frame through the labeling pipeline, flushes it, then
// reads object records 1..n-1 out of the data table one per handshake.
// Ports: clk, reset (async, active-high); start frame request;
//        pix_valid upstream pixel available; num_labels next free label;
//        obj_x_in/obj_y_in table data for obj_id; en pipeline advance;
//        flush background forcing; x, y raster coordinate; obj_id table address;
//        rec record channel (master); busy not idle; done end-of-readout pulse.
module ccl_frame_ctrl
  import ccl_frame_ctrl_pkg::*;
#(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int DRAIN_CYC = 4,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pix_valid,
  input  logic [WORD_SIZE-1:0] num_labels,
  input  logic [LOC_SIZE-1:0]  obj_x_in,
  input  logic [LOC_SIZE-1:0]  obj_y_in,
  output logic                 en,
  output logic                 flush,
  output logic [LOC_SIZE-1:0]  x,
  output logic [LOC_SIZE-1:0]  y,
  output logic [WORD_SIZE-1:0] obj_id,
  ccl_frame_ctrl_if.master     rec,
  output logic                 busy,
  output logic                 done
);

  state_t               state, state_nxt;
  logic [15:0]          cnt;
  logic [WORD_SIZE-1:0] n_lat;
  logic                 advance, last_pix, drain_end, read_end, hs, last_obj;

  assign advance   = (state == SCAN) && pix_valid;
  assign drain_end = (state == DRAIN) && (cnt == 16'(DRAIN_CYC - 1));
  assign read_end  = (state == READ) && (cnt == 16'(RD_LAT - 1));
  assign hs        = (state == PRESENT) && rec.out_ready;
  // n > 1 whenever readout runs, so n_lat - 1 cannot underflow here
  assign last_obj  = (obj_id == n_lat - WORD_SIZE'(1));

  assign rec.out_valid = (state == PRESENT);

  raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_raster (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state == IDLE) && start),
    .advance (advance),
    .x       (x),
    .y       (y),
    .last    (last_pix)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    en        = 1'b0;
    flush     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
        en = pix_valid;
        if (advance && last_pix) state_nxt = DRAIN;
      end
      DRAIN: begin
        en    = 1'b1;
        flush = 1'b1;
        // label 0 is background, so fewer than two labels means no objects
        if (drain_end) state_nxt = (num_labels > WORD_SIZE'(1)) ? READ : FINISH;
      end
      READ: begin
        if (read_end) state_nxt = PRESENT;
      end
      PRESENT: begin
        if (hs) state_nxt = last_obj ? FINISH : READ;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      n_lat      <= '0;
      obj_id     <= '0;
      rec.out_id <= '0;
      rec.out_x  <= '0;
      rec.out_y  <= '0;
    end else begin
      // cnt times the DRAIN and READ dwell; it restarts on every state change
      if (state_nxt != state)                  cnt <= '0;
      else if (state == DRAIN || state == READ) cnt <= cnt + 16'd1;

      if (drain_end) begin
        n_lat  <= num_labels;
        obj_id <= WORD_SIZE'(1);
      end else if (hs && !last_obj) begin
        obj_id <= obj_id + WORD_SIZE'(1);
      end

      if (read_end) begin
        rec.out_id <= obj_id;
        rec.out_x  <= obj_x_in;
        rec.out_y  <= obj_y_in;
      end
    end
  end

endmodule

// File: tb/tb_ccl_frame_ctrl.sv
// tb/tb_ccl_frame_ctrl.sv - directed vector bench for ccl_frame_ctrl
module tb_ccl_frame_ctrl;
  import ccl_frame_ctrl_pkg::*;

  localparam int W = 4, H = 3, DC = 4, RL = 1;

  logic                 clk = 1'b0;
  logic                 reset, start, pix_valid;
  logic [WORD_SIZE-1:0] num_labels, obj_id;
  logic [LOC_SIZE-1:0]  obj_x_in, obj_y_in, x, y;
  logic                 en, flush, busy, done;

  ccl_frame_ctrl_if rec_if();

  ccl_frame_ctrl #(.IMG_W(W), .IMG_H(H), .DRAIN_CYC(DC), .RD_LAT(RL)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
    .num_labels(num_labels), .obj_x_in(obj_x_in), .obj_y_in(obj_y_in),
    .en(en), .flush(flush), .x(x), .y(y), .obj_id(obj_id),
    .rec(rec_if), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [LOC_SIZE-1:0] tx(input int id);
    return LOC_SIZE'(id * 7 + 1);
  endfunction
  function automatic logic [LOC_SIZE-1:0] ty(input int id);
    return LOC_SIZE'(id * 5 + 2);
  endfunction

  // data table model: centroid is a fixed function of the address
  assign obj_x_in = tx(int'(obj_id));
  assign obj_y_in = ty(int'(obj_id));

  typedef struct {
    logic start, pv, rdy;
    logic en, fl;
    int   x, y;
    logic busy, valid;
    int   obj, oid, ox, oy;
    logic done;
  } vec_t;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  function automatic logic [60:0] pk(input logic e, f, input int px, py, input logic b, v,
                                     input int o, oi, ox, oy, input logic d);
    return {e, f, LOC_SIZE'(px), LOC_SIZE'(py), b, v, WORD_SIZE'(o), WORD_SIZE'(oi),
            LOC_SIZE'(ox), LOC_SIZE'(oy), d};
  endfunction

  function automatic logic [60:0] act_pk();
    return {en, flush, x, y, busy, rec_if.out_valid, obj_id, rec_if.out_id,
            rec_if.out_x, rec_if.out_y, done};
  endfunction

  function automatic vec_t mk(input logic s, p, r, e, f, input int px, py, input logic b, v,
                              input int o, oi, ox, oy, input logic d);
    vec_t t;
    t.start = s; t.pv = p; t.rdy = r; t.en = e; t.fl = f; t.x = px; t.y = py;
    t.busy = b; t.valid = v; t.obj = o; t.oid = oi; t.ox = ox; t.oy = oy; t.done = d;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame with pix_valid high; stalls the record for stall_id for
  // stall_len cycles; num_labels switches to nl_after once scanning is over.
  task automatic run_frame(input int nl, input int nl_after, input int stall_id,
                           input int stall_len, output int nrec, output int bad,
                           output int done_gap);
    int exp_id, stalled, last_acc, prev_acc, done_cyc;
    num_labels = WORD_SIZE'(nl);
    pix_valid = 1'b1; rec_if.out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    nrec = 0; bad = 0; exp_id = 1; stalled = 0;
    last_acc = -100; prev_acc = -1; done_cyc = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (busy && !en && !flush) num_labels = WORD_SIZE'(nl_after);
      rec_if.out_ready = 1'b1;
      if (rec_if.out_valid && int'(rec_if.out_id) == stall_id && stalled < stall_len) begin
        rec_if.out_ready = 1'b0;
        stalled++;
        if (int'(rec_if.out_id) != stall_id || rec_if.out_x != tx(stall_id) ||
            rec_if.out_y != ty(stall_id)) bad++;
      end
      #1;
      if (rec_if.out_valid && rec_if.out_ready) begin
        if (int'(rec_if.out_id) != exp_id || rec_if.out_x != tx(exp_id) ||
            rec_if.out_y != ty(exp_id)) bad++;
        if (stall_len == 0 && prev_acc >= 0 && cyc - prev_acc != RL + 1) bad++;
        prev_acc = cyc;
        exp_id++; nrec++; last_acc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        step();
        break;
      end
      step();
    end
    done_gap = (done_cyc < 0) ? -1 : done_cyc - last_acc;
    rec_if.out_ready = 1'b1;
  endtask

  vec_t vecs[25];

  initial begin
    int idx, bad, dc, nrec, gap, saw_valid;

    vecs[0] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      vecs[1 + i] = mk(0, 1, 1, 1, 0, i % 4, i / 4, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      vecs[13 + i] = mk(0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 8, 7, 0);
    vecs[19] = mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 2, 1, 8, 7, 0);
    vecs[20] = mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 2, 2, 15, 12, 0);
    vecs[21] = mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 3, 2, 15, 12, 0);
    vecs[22] = mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 3, 3, 22, 17, 0);
    vecs[23] = mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 3, 3, 22, 17, 1);
    vecs[24] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 3, 22, 17, 0);

    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; rec_if.out_ready = 1'b0;
    num_labels = WORD_SIZE'(4);
    @(negedge clk);
    check("reset_state", 64'(act_pk()), 64'(61'd0));
    step(); step();
    reset = 1'b0;
    pix_valid = 1'b1; rec_if.out_ready = 1'b1;
    step(); step(); step();
    @(negedge clk);
    check("idle_after_reset", 64'(act_pk()), 64'(61'd0));
    step();

    // full frame, continuous pixels, three objects
    for (int i = 0; i < 25; i++) begin
      start = vecs[i].start; pix_valid = vecs[i].pv; rec_if.out_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'(act_pk()),
            64'(pk(vecs[i].en, vecs[i].fl, vecs[i].x, vecs[i].y, vecs[i].busy,
                   vecs[i].valid, vecs[i].obj, vecs[i].oid, vecs[i].ox, vecs[i].oy,
                   vecs[i].done)));
      step();
    end
    start = 1'b0;

    // toggled pix_valid, a stray start mid-scan, then n=1 (no objects)
    num_labels = WORD_SIZE'(1);
    start = 1'b1; pix_valid = 1'b0;
    step();
    start = 1'b0;
    idx = 0; bad = 0; saw_valid = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      pix_valid = cyc[0];
      start = (cyc == 5);
      @(negedge clk);
      if (flush) break;
      if (en !== pix_valid || int'(x) != idx % W || int'(y) != idx / W) bad++;
      if (pix_valid) idx++;
      step();
    end
    start = 1'b0;
    check("toggle_xy_hold", 64'(bad), 64'd0);
    check("toggle_en_count", 64'(idx), 64'd12);
    dc = 0;
    while (flush && dc < 20) begin
      if (!en) bad++;
      if (rec_if.out_valid) saw_valid++;
      dc++;
      step();
      @(negedge clk);
    end
    check("drain_cycles", 64'(dc), 64'd4);
    check("n1_done_after_drain", 64'({done, rec_if.out_valid, busy}), 64'(3'b101));
    step();
    @(negedge clk);
    check("n1_idle", 64'({done, busy, en, saw_valid != 0}), 64'd0);
    step();

    // backpressure on id 2, num_labels changes after the latch
    run_frame(4, 2, 2, 5, nrec, bad, gap);
    check("stall_records", 64'(nrec), 64'd3);
    check("stall_data", 64'(bad), 64'd0);
    check("stall_done_gap", 64'(gap), 64'd1);

    // saturated label count
    run_frame(255, 255, 0, 0, nrec, bad, gap);
    check("sat_records", 64'(nrec), 64'd254);
    check("sat_data_rate", 64'(bad), 64'd0);
    check("sat_done_gap", 64'(gap), 64'd1);
    @(negedge clk);
    check("sat_last_id", 64'(obj_id), 64'd254);
    step();

    // reset during READ, start held during the reset pulse
    num_labels = WORD_SIZE'(4); pix_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (busy && !en && !rec_if.out_valid && !done) begin
        idx = 1;
        break;
      end
      step();
    end
    check("reached_read", 64'(idx), 64'd1);
    reset = 1'b1; start = 1'b1;
    #1;
    check("reset_mid_read", 64'(act_pk()), 64'(61'd0));
    step(); step();
    reset = 1'b0; start = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (act_pk() != 61'd0) bad++;
      step();
    end
    check("no_activity_after_reset", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

endmodule
